// File: rtl/mandel_pkg.sv
// Shared types and widths for the Mandelbrot colour path: iteration width,
// reciprocal precision and the reciprocal generator's FSM encoding.
package mandel_pkg;

    localparam int ITER_W  = 10;
    localparam int RECIP_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2
    } recip_state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to
// subtract the divisor, keep the difference only when it does not borrow.
module restoring_div_step #(
    parameter int ITER_W = 10
) (
    input  logic [ITER_W:0]   rem,
    input  logic              dividend_bit,
    input  logic [ITER_W-1:0] divisor,
    output logic [ITER_W:0]   rem_next,
    output logic              q_bit
);

    logic [ITER_W+1:0] partial_s;
    logic [ITER_W+2:0] diff_s;
    logic              borrow_s;
    logic              unused_s;

    assign partial_s = {rem, dividend_bit};
    assign diff_s    = {1'b0, partial_s} - {3'b000, divisor};
    assign borrow_s  = diff_s[ITER_W+2];

    // rem < divisor always holds, so the top bit of the partial remainder is zero
    assign unused_s  = ^{partial_s[ITER_W+1], diff_s[ITER_W+1]};

    assign q_bit    = ~borrow_s;
    assign rem_next = borrow_s ? partial_s[ITER_W:0] : diff_s[ITER_W:0];

endmodule

// File: rtl/iter_recip_gen.sv
// Generates floor(2^RECIP_W / max_iterations) in Q0.RECIP_W with a bit-serial
// restoring divider; recomputes on reset, input change or explicit request.
module iter_recip_gen
    import mandel_pkg::*;
#(
    parameter int ITER_W  = mandel_pkg::ITER_W,
    parameter int RECIP_W = mandel_pkg::RECIP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ITER_W-1:0]  max_iterations,
    input  logic               recompute,
    output logic [RECIP_W-1:0] max_iter_recip,
    output logic               recip_valid,
    output logic               busy
);

    localparam int CNT_W = $clog2(RECIP_W + 2);

    recip_state_t       state_r;
    recip_state_t       state_nxt_s;

    logic [ITER_W-1:0]  last_iter_r;
    logic [ITER_W-1:0]  divisor_r;
    logic               pending_r;
    logic [ITER_W:0]    rem_r;
    logic [RECIP_W:0]   dividend_r;
    logic [RECIP_W-1:0] quotient_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [RECIP_W-1:0] recip_r;
    logic               valid_r;
    logic               busy_r;

    logic               start_s;
    logic               latch_s;
    logic               load_div_s;
    logic               div_step_s;
    logic               write_res_s;
    logic               write_zero_s;
    logic [ITER_W:0]    rem_next_s;
    logic               q_bit_s;
    logic [RECIP_W:0]   quo_next_s;

    restoring_div_step #(
        .ITER_W (ITER_W)
    ) u_step (
        .rem          (rem_r),
        .dividend_bit (dividend_r[RECIP_W]),
        .divisor      (divisor_r),
        .rem_next     (rem_next_s),
        .q_bit        (q_bit_s)
    );

    // Only the low RECIP_W quotient bits need storage; the MSB appears on the final step
    assign quo_next_s = {quotient_r, q_bit_s};

    // Next-state and datapath control; a change or request always restarts from LOAD
    always_comb begin
        start_s      = (max_iterations != last_iter_r) || recompute;
        state_nxt_s  = state_r;
        latch_s      = 1'b0;
        load_div_s   = 1'b0;
        div_step_s   = 1'b0;
        write_res_s  = 1'b0;
        write_zero_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s || pending_r) begin
                    latch_s     = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (start_s) begin
                    latch_s     = 1'b1;
                    state_nxt_s = LOAD;
                end else if (divisor_r == '0) begin
                    write_zero_s = 1'b1;
                    state_nxt_s  = IDLE;
                end else begin
                    load_div_s  = 1'b1;
                    state_nxt_s = DIV;
                end
            end
            DIV: begin
                if (start_s) begin
                    latch_s     = 1'b1;
                    state_nxt_s = LOAD;
                end else if (cnt_r == CNT_W'(1)) begin
                    div_step_s  = 1'b1;
                    write_res_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    div_step_s  = 1'b1;
                    state_nxt_s = DIV;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Divider datapath and result registers; the result only changes on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_iter_r <= '0;
            divisor_r   <= '0;
            pending_r   <= 1'b1;
            rem_r       <= '0;
            dividend_r  <= '0;
            quotient_r  <= '0;
            cnt_r       <= '0;
            recip_r     <= '0;
            valid_r     <= 1'b0;
        end else begin
            if (latch_s) begin
                divisor_r   <= max_iterations;
                last_iter_r <= max_iterations;
                pending_r   <= 1'b0;
                valid_r     <= 1'b0;
            end
            if (load_div_s) begin
                rem_r      <= '0;
                dividend_r <= {1'b1, {RECIP_W{1'b0}}};
                quotient_r <= '0;
                cnt_r      <= CNT_W'(RECIP_W + 1);
            end
            if (div_step_s) begin
                rem_r      <= rem_next_s;
                dividend_r <= {dividend_r[RECIP_W-1:0], 1'b0};
                quotient_r <= quo_next_s[RECIP_W-1:0];
                cnt_r      <= cnt_r - CNT_W'(1);
            end
            if (write_res_s) begin
                recip_r <= quo_next_s[RECIP_W] ? {RECIP_W{1'b1}} : quo_next_s[RECIP_W-1:0];
                valid_r <= 1'b1;
            end
            if (write_zero_s) begin
                recip_r <= '0;
                valid_r <= 1'b1;
            end
        end
    end

    assign max_iter_recip = recip_r;
    assign recip_valid    = valid_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_iter_recip_gen.sv
// Directed bench for iter_recip_gen: reset state, latency, output hold,
// divisor boundaries, mid-division abort, recompute pulse and mid-division reset.
module tb_iter_recip_gen;

    logic        clk;
    logic        rst_n;
    logic [9:0]  max_iterations;
    logic        recompute;
    logic [15:0] max_iter_recip;
    logic        recip_valid;
    logic        busy;

    int total;
    int bad;

    iter_recip_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .max_iterations (max_iterations),
        .recompute      (recompute),
        .max_iter_recip (max_iter_recip),
        .recip_valid    (recip_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for recip_valid, checking the old output is held and the latency/busy counts
    task automatic wait_result(input string tag, input logic [15:0] exp_val,
                               input int exp_edges, input logic [15:0] hold_val);
        int edges;
        int busy_cnt;
        bit done;
        edges    = 0;
        busy_cnt = 0;
        done     = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            recompute = 1'b0;
            if (busy) busy_cnt++;
            if (recip_valid) done = 1'b1;
            else check({tag, "_hold"}, 32'(max_iter_recip), 32'(hold_val));
        end
        check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        check({tag, "_busycnt"}, 32'(busy_cnt), 32'(exp_edges - 1));
        check({tag, "_val"}, 32'(max_iter_recip), 32'(exp_val));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        max_iterations = 10'd1000;
        recompute      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_recip", 32'(max_iter_recip), 32'h0);
        check("rst_valid", 32'(recip_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Reset release with 1000: 65536/1000 = 65
        rst_n = 1'b1;
        wait_result("init1000", 16'h0041, 19, 16'h0000);

        // 1000 -> 3 while idle: 65536/3 = 21845
        max_iterations = 10'd3;
        wait_result("to3", 16'h5555, 19, 16'h0041);

        // Divisor boundaries
        max_iterations = 10'd1;
        wait_result("div1", 16'hFFFF, 19, 16'h5555);
        max_iterations = 10'd256;
        wait_result("div256", 16'h0100, 19, 16'hFFFF);
        max_iterations = 10'd1023;
        wait_result("div1023", 16'h0040, 19, 16'h0100);
        max_iterations = 10'd0;
        wait_result("div0", 16'h0000, 2, 16'h0040);

        // 512 then change to 7 during DIV cycle 9: 65536/7 = 9362
        max_iterations = 10'd512;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("d512_valid", 32'(recip_valid), 32'd0);
            check("d512_hold", 32'(max_iter_recip), 32'h0);
        end
        max_iterations = 10'd7;
        wait_result("chg7", 16'h2492, 19, 16'h0000);

        // 100 then a recompute pulse with the input unchanged: 65536/100 = 655
        max_iterations = 10'd100;
        wait_result("div100", 16'h028F, 19, 16'h2492);
        recompute = 1'b1;
        wait_result("recomp", 16'h028F, 19, 16'h028F);

        // Reset during DIV: 65536/300 = 218
        max_iterations = 10'd300;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_recip", 32'(max_iter_recip), 32'h0);
        check("mid_rst_valid", 32'(recip_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_result("after_rst", 16'h00DA, 19, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
